// File: rtl/video_timing_gen.sv
// video_timing_gen: run-time programmable raster timing generator.
// Timing registers are written into a shadow bank and copied to the active
// bank atomically at the end of each frame. Sync pulses can be shifted by
// signed offsets that wrap modulo the line/frame length.
module video_timing_gen #(
    parameter int HW          = 9,
    parameter int VW          = 9,
    parameter int HTOTAL_D    = 386,
    parameter int HBL_START_D = 336,
    parameter int HBL_END_D   = 16,
    parameter int HS_START_D  = 347,
    parameter int HS_END_D    = 363,
    parameter int VTOTAL_D    = 262,
    parameter int VBL_START_D = 256,
    parameter int VBL_END_D   = 16,
    parameter int VS_START_D  = 0,
    parameter int VS_END_D    = 8,
    parameter int VIRQ_D      = 256,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1,
    localparam int CW         = (HW > VW) ? HW : VW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_pix,
    input  logic signed [HW-1:0] hs_offset,
    input  logic signed [VW-1:0] vs_offset,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_addr,
    input  logic [CW-1:0]        cfg_data,
    output logic                 cfg_pending,
    output logic [HW-1:0]        hc,
    output logic [VW-1:0]        vc,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 hbl,
    output logic                 vbl,
    output logic                 de,
    output logic                 line_start,
    output logic                 frame_start,
    output logic                 virq
);

    typedef struct packed {
        logic [HW-1:0] htotal;
        logic [HW-1:0] hbl_start;
        logic [HW-1:0] hbl_end;
        logic [HW-1:0] hs_start;
        logic [HW-1:0] hs_end;
        logic [VW-1:0] vtotal;
        logic [VW-1:0] vbl_start;
        logic [VW-1:0] vbl_end;
        logic [VW-1:0] vs_start;
        logic [VW-1:0] vs_end;
        logic [VW-1:0] virq;
    } timing_t;

    localparam timing_t DEFAULTS = '{
        htotal:    HW'(HTOTAL_D),
        hbl_start: HW'(HBL_START_D),
        hbl_end:   HW'(HBL_END_D),
        hs_start:  HW'(HS_START_D),
        hs_end:    HW'(HS_END_D),
        vtotal:    VW'(VTOTAL_D),
        vbl_start: VW'(VBL_START_D),
        vbl_end:   VW'(VBL_END_D),
        vs_start:  VW'(VS_START_D),
        vs_end:    VW'(VS_END_D),
        virq:      VW'(VIRQ_D)
    };

    timing_t       act_q, shd_q;
    logic          pend_q;
    logic [HW-1:0] h_q;
    logic [VW-1:0] v_q, v_d;
    logic          hbl_q, vbl_q, hs_q, vs_q, de_q;
    logic          line_start_q, frame_start_q, virq_q;
    logic          h_wrap, v_wrap, commit;
    logic [HW-1:0] hs_start_t, hs_end_t;
    logic [VW-1:0] vs_start_t, vs_end_t;

    // Shift a sync edge by a signed offset, wrapping into 0..total.
    function automatic logic [HW-1:0] h_target(input logic [HW-1:0] base,
                                               input logic [HW-1:0] off,
                                               input logic [HW-1:0] total);
        logic signed [HW+1:0] t;
        logic signed [HW+1:0] span;
        span = $signed({2'b00, total} + {{(HW+1){1'b0}}, 1'b1});
        t    = $signed({2'b00, base}) + $signed({{2{off[HW-1]}}, off});
        if (t[HW+1])
            t = t + span;
        else if (t >= span)
            t = t - span;
        return t[HW-1:0];
    endfunction

    function automatic logic [VW-1:0] v_target(input logic [VW-1:0] base,
                                               input logic [VW-1:0] off,
                                               input logic [VW-1:0] total);
        logic signed [VW+1:0] t;
        logic signed [VW+1:0] span;
        span = $signed({2'b00, total} + {{(VW+1){1'b0}}, 1'b1});
        t    = $signed({2'b00, base}) + $signed({{2{off[VW-1]}}, off});
        if (t[VW+1])
            t = t + span;
        else if (t >= span)
            t = t - span;
        return t[VW-1:0];
    endfunction

    assign hs_start_t = h_target(act_q.hs_start, hs_offset, act_q.htotal);
    assign hs_end_t   = h_target(act_q.hs_end,   hs_offset, act_q.htotal);
    assign vs_start_t = v_target(act_q.vs_start, vs_offset, act_q.vtotal);
    assign vs_end_t   = v_target(act_q.vs_end,   vs_offset, act_q.vtotal);

    assign h_wrap = (h_q == act_q.htotal);
    assign v_wrap = (v_q == act_q.vtotal);
    assign commit = clk_pix && h_wrap && v_wrap;
    assign v_d    = v_wrap ? '0 : v_q + 1'b1;

    // Shadow writes (any clk) and frame-boundary commit of shadow to active.
    // Commit copies the pre-write shadow; a same-cycle write keeps pending set.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_q  <= DEFAULTS;
            shd_q  <= DEFAULTS;
            pend_q <= 1'b0;
        end else begin
            if (commit) begin
                act_q  <= shd_q;
                pend_q <= 1'b0;
            end
            if (cfg_we && (cfg_addr <= 4'd10)) begin
                pend_q <= 1'b1;
                case (cfg_addr)
                    4'd0:    shd_q.htotal    <= cfg_data[HW-1:0];
                    4'd1:    shd_q.hbl_start <= cfg_data[HW-1:0];
                    4'd2:    shd_q.hbl_end   <= cfg_data[HW-1:0];
                    4'd3:    shd_q.hs_start  <= cfg_data[HW-1:0];
                    4'd4:    shd_q.hs_end    <= cfg_data[HW-1:0];
                    4'd5:    shd_q.vtotal    <= cfg_data[VW-1:0];
                    4'd6:    shd_q.vbl_start <= cfg_data[VW-1:0];
                    4'd7:    shd_q.vbl_end   <= cfg_data[VW-1:0];
                    4'd8:    shd_q.vs_start  <= cfg_data[VW-1:0];
                    4'd9:    shd_q.vs_end    <= cfg_data[VW-1:0];
                    4'd10:   shd_q.virq      <= cfg_data[VW-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Raster counters, blanking/sync edge tracking and one-clk strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q           <= '0;
            v_q           <= '0;
            hbl_q         <= 1'b0;
            vbl_q         <= 1'b0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            virq_q        <= 1'b0;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            virq_q        <= 1'b0;
            if (clk_pix) begin
                if (h_wrap) begin
                    h_q           <= '0;
                    v_q           <= v_d;
                    line_start_q  <= 1'b1;
                    frame_start_q <= v_wrap;
                    virq_q        <= (v_d == act_q.virq);
                end else begin
                    h_q <= h_q + 1'b1;
                end

                if (h_q == act_q.hbl_start)    hbl_q <= 1'b1;
                else if (h_q == act_q.hbl_end) hbl_q <= 1'b0;

                if (v_q == act_q.vbl_start)    vbl_q <= 1'b1;
                else if (v_q == act_q.vbl_end) vbl_q <= 1'b0;

                if (h_q == hs_start_t)         hs_q <= 1'b1;
                else if (h_q == hs_end_t)      hs_q <= 1'b0;

                if (v_q == vs_start_t)         vs_q <= 1'b1;
                else if (v_q == vs_end_t)      vs_q <= 1'b0;

                de_q <= ~hbl_q & ~vbl_q;
            end
        end
    end

    assign cfg_pending = pend_q;
    assign hc          = h_q;
    assign vc          = v_q;
    assign hbl         = hbl_q;
    assign vbl         = vbl_q;
    assign hsync       = hs_q ^ ~HS_POL;
    assign vsync       = vs_q ^ ~VS_POL;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign virq        = virq_q;

endmodule
